udp_tx_arbiter: RTL and testbench
=================================

# udp_tx_arbiter

Packet-granular round-robin arbiter that shares a single UDP user TX port (112-bit header stream plus 64-bit AXI-Stream payload) of `fpga_core` among NUM_PORTS requesters. It sits between on-board clients, such as the host-side pipeline or local test generators, and the `s_usr_hdr_*` / `s_usr_payload_axis_*` inputs of the network stack. It never interleaves packets. Each grant carries exactly one header beat followed by that header's payload beats.

## Interface
Parameters:
- NUM_PORTS, 4: requester count, 2..8.
- HDR_WIDTH, 112: header width; layout {length[15:0], dest_port, src_port, dest_ip, src_ip}, length = bits [111:96].
- DATA_WIDTH, 64: payload width; KEEP_WIDTH = DATA_WIDTH/8.

Ports:
- clk  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- s_hdr_data  in  NUM_PORTS*HDR_WIDTH  per-requester header; requester i occupies slice [i*HDR_WIDTH +: HDR_WIDTH].
- s_hdr_valid  in  NUM_PORTS  header valid per requester.
- s_hdr_ready  out  NUM_PORTS  header ready per requester.
- s_payload_axis_tdata  in  NUM_PORTS*DATA_WIDTH  payload data per requester.
- s_payload_axis_tkeep  in  NUM_PORTS*KEEP_WIDTH  byte enables per requester.
- s_payload_axis_tvalid / tlast / tuser  in  NUM_PORTS each  payload valid, last and user per requester.
- s_payload_axis_tready  out  NUM_PORTS  payload ready per requester.
- m_hdr_data  out  HDR_WIDTH  header toward `fpga_core`.
- m_hdr_valid  out  1  header valid toward `fpga_core`.
- m_hdr_ready  in  1  header ready from `fpga_core`.
- m_payload_axis_tdata / tkeep / tvalid / tlast / tuser  out  DATA_WIDTH / KEEP_WIDTH / 1 / 1 / 1  payload toward `fpga_core`.
- m_payload_axis_tready  in  1  payload ready from `fpga_core`.
- grant_idx  out  $clog2(NUM_PORTS)  index of the current or last granted requester.
- busy  out  1  high in HDR and PLD.
- pkt_count  out  32  count of completed grants, wrapping.

## Operation
- FSM states: IDLE, HDR, PLD.
- IDLE:
  - If any s_hdr_valid is high, select the first requester with valid set, scanning upward from rr_ptr with wrap-around.
  - Register the selection into grant_idx and go to HDR.
  - If no requester is valid, remain in IDLE.
- HDR:
  - m_hdr_data = s_hdr_data[grant]; m_hdr_valid = s_hdr_valid[grant]; s_hdr_ready[grant] = m_hdr_ready.
  - On handshake, if length <= 8 (header-only datagram), complete the grant and go to IDLE.
  - On handshake with length > 8, go to PLD.
- PLD:
  - Payload signals of the granted requester pass through combinationally; s_payload_axis_tready[grant] = m_payload_axis_tready.
  - On a handshake with tlast = 1, complete the grant and go to IDLE.
- Completing a grant: rr_ptr <= (grant_idx + 1) mod NUM_PORTS; pkt_count increments by 1.
- Non-granted requesters see ready = 0 on both streams at all times.
- In IDLE, every m_*valid and s_*ready output is 0.
- A requester may present payload before its header; that payload is stalled until the header is accepted.
- The arbiter does not check payload length against the length field; tlast alone ends the grant.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state = IDLE, rr_ptr = 0, grant_idx = 0, pkt_count = 0.
  - All valid and ready outputs = 0; busy = 0.
- Arbitration latency: s_hdr_valid rising in IDLE gives m_hdr_valid = 1 on the next cycle.
- Pass-through paths are combinational: no added latency and no buffering, so a downstream stall propagates in the same cycle.
- Inter-packet gap: exactly one IDLE cycle between the tlast (or header-only) handshake and the next m_hdr_valid.
- One requester with continuous traffic is granted every packet.
- If several requesters are valid, no requester waits more than NUM_PORTS-1 packets.
- A requester that deasserts s_hdr_valid while in HDR keeps its grant; the arbiter waits.
- Reset asserted mid-packet drops the grant at once. Downstream sees a truncated packet, which is accepted behaviour because the whole stack resets together.
- pkt_count wraps from 0xFFFFFFFF to 0.

## Test plan
- Single requester: port 0 sends header (length = 24) and 2 payload beats 0x0f0f0f0f0f0f0f0f then 0x0101010101010101 (tlast) -> m_hdr_valid one cycle after s_hdr_valid; both beats appear unchanged; pkt_count = 1; busy low afterwards.
- Round robin: ports 0, 1 and 3 all request continuously with 2-beat packets -> grant order 0, 1, 3, 0, 1, 3; one IDLE cycle between packets; port 2 never granted.
- Header-only datagram: port 2 sends length = 8 with no payload -> FSM goes HDR -> IDLE with no PLD cycle; pkt_count increments; rr_ptr = 3.
- Backpressure: m_payload_axis_tready toggles 1,0,0,1 during a 4-beat packet -> no beat lost or duplicated; s_payload_axis_tready[grant] mirrors the toggle pattern; other requesters' readies stay 0.
- Early payload: port 1 asserts payload tvalid 5 cycles before its header -> s_payload_axis_tready[1] = 0 until the header handshake, then data flows.
- Reset mid-packet: assert rst during the second PLD beat -> all outputs 0 in the same cycle; after release, arbitration restarts from port 0.

Source files
------------

// File: rtl/udp_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UDP header + payload TX port.
// Each grant passes one header beat and then that header's payload beats; packets never interleave.
module udp_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int HDR_WIDTH  = 112,
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS*HDR_WIDTH-1:0]   s_hdr_data,
  input  logic [NUM_PORTS-1:0]             s_hdr_valid,
  output logic [NUM_PORTS-1:0]             s_hdr_ready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_payload_axis_tdata,
  input  logic [NUM_PORTS*KEEP_WIDTH-1:0]  s_payload_axis_tkeep,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tvalid,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tlast,
  input  logic [NUM_PORTS-1:0]             s_payload_axis_tuser,
  output logic [NUM_PORTS-1:0]             s_payload_axis_tready,
  output logic [HDR_WIDTH-1:0]             m_hdr_data,
  output logic                             m_hdr_valid,
  input  logic                             m_hdr_ready,
  output logic [DATA_WIDTH-1:0]            m_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0]            m_payload_axis_tkeep,
  output logic                             m_payload_axis_tvalid,
  output logic                             m_payload_axis_tlast,
  output logic                             m_payload_axis_tuser,
  input  logic                             m_payload_axis_tready,
  output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
  output logic                             busy,
  output logic [31:0]                      pkt_count
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  typedef enum logic [1:0] {IDLE, HDR, PLD} state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] next_ptr;
  logic             sel_found;
  logic             hdr_fire;
  logic             pld_last_fire;
  logic             hdr_only;

  // Scan downward so the candidate closest to rr_ptr is the last one written and wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_PORTS);
      if (s_hdr_valid[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    m_hdr_data            = '0;
    m_hdr_valid           = 1'b0;
    s_hdr_ready           = '0;
    m_payload_axis_tdata  = '0;
    m_payload_axis_tkeep  = '0;
    m_payload_axis_tvalid = 1'b0;
    m_payload_axis_tlast  = 1'b0;
    m_payload_axis_tuser  = 1'b0;
    s_payload_axis_tready = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (IDX_W'(i) == grant_idx) begin
        if (state == HDR) begin
          m_hdr_data     = s_hdr_data[i*HDR_WIDTH +: HDR_WIDTH];
          m_hdr_valid    = s_hdr_valid[i];
          s_hdr_ready[i] = m_hdr_ready;
        end
        if (state == PLD) begin
          m_payload_axis_tdata     = s_payload_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
          m_payload_axis_tkeep     = s_payload_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
          m_payload_axis_tvalid    = s_payload_axis_tvalid[i];
          m_payload_axis_tlast     = s_payload_axis_tlast[i];
          m_payload_axis_tuser     = s_payload_axis_tuser[i];
          s_payload_axis_tready[i] = m_payload_axis_tready;
        end
      end
    end
  end

  assign hdr_fire      = m_hdr_valid && m_hdr_ready;
  assign pld_last_fire = m_payload_axis_tvalid && m_payload_axis_tready && m_payload_axis_tlast;
  assign hdr_only      = (m_hdr_data[HDR_WIDTH-1 -: 16] <= 16'd8);
  assign next_ptr      = (grant_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;
  assign busy          = (state != IDLE);

  // Datagrams of 8 bytes or less are header-only and complete on the header handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      grant_idx <= '0;
      pkt_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            grant_idx <= sel_idx;
            state     <= HDR;
          end
        end
        HDR: begin
          if (hdr_fire) begin
            if (hdr_only) begin
              rr_ptr    <= next_ptr;
              pkt_count <= pkt_count + 32'd1;
              state     <= IDLE;
            end else begin
              state <= PLD;
            end
          end
        end
        PLD: begin
          if (pld_last_fire) begin
            rr_ptr    <= next_ptr;
            pkt_count <= pkt_count + 32'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udp_tx_arbiter.sv
// Scoreboard bench for udp_tx_arbiter: per-port source queues drive requesters,
// expected output beats are queued in grant order and checked by an independent monitor.
module tb_udp_tx_arbiter;

  localparam int NP = 4;
  localparam int HW = 112;
  localparam int DW = 64;
  localparam int KW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NP*HW-1:0]  s_hdr_data;
  logic [NP-1:0]     s_hdr_valid;
  logic [NP-1:0]     s_hdr_ready;
  logic [NP*DW-1:0]  s_payload_axis_tdata;
  logic [NP*KW-1:0]  s_payload_axis_tkeep;
  logic [NP-1:0]     s_payload_axis_tvalid;
  logic [NP-1:0]     s_payload_axis_tlast;
  logic [NP-1:0]     s_payload_axis_tuser;
  logic [NP-1:0]     s_payload_axis_tready;
  logic [HW-1:0]     m_hdr_data;
  logic              m_hdr_valid;
  logic              m_hdr_ready;
  logic [DW-1:0]     m_payload_axis_tdata;
  logic [KW-1:0]     m_payload_axis_tkeep;
  logic              m_payload_axis_tvalid;
  logic              m_payload_axis_tlast;
  logic              m_payload_axis_tuser;
  logic              m_payload_axis_tready;
  logic [1:0]        grant_idx;
  logic              busy;
  logic [31:0]       pkt_count;

  udp_tx_arbiter #(.NUM_PORTS(NP), .HDR_WIDTH(HW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_hdr_data(s_hdr_data), .s_hdr_valid(s_hdr_valid), .s_hdr_ready(s_hdr_ready),
    .s_payload_axis_tdata(s_payload_axis_tdata), .s_payload_axis_tkeep(s_payload_axis_tkeep),
    .s_payload_axis_tvalid(s_payload_axis_tvalid), .s_payload_axis_tlast(s_payload_axis_tlast),
    .s_payload_axis_tuser(s_payload_axis_tuser), .s_payload_axis_tready(s_payload_axis_tready),
    .m_hdr_data(m_hdr_data), .m_hdr_valid(m_hdr_valid), .m_hdr_ready(m_hdr_ready),
    .m_payload_axis_tdata(m_payload_axis_tdata), .m_payload_axis_tkeep(m_payload_axis_tkeep),
    .m_payload_axis_tvalid(m_payload_axis_tvalid), .m_payload_axis_tlast(m_payload_axis_tlast),
    .m_payload_axis_tuser(m_payload_axis_tuser), .m_payload_axis_tready(m_payload_axis_tready),
    .grant_idx(grant_idx), .busy(busy), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit            is_hdr;
    int            port;
    logic [HW-1:0] hdr;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    bit            last;
    bit            user;
  } exp_t;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    bit            last;
    bit            user;
  } beat_t;

  exp_t          exp_q[$];
  logic [HW-1:0] hdr_src[NP][$];
  beat_t         pld_src[NP][$];
  int            hold[NP];
  bit            bp_mode = 1'b0;
  int            bp_i = 0;
  logic [3:0]    bp_pat = 4'b1001;
  bit            check_gap = 1'b0;
  int            nchk = 0;
  int            npass = 0;

  bit            mon_in_pld = 1'b0;
  int            mon_cur = 0;
  int            mon_last_end = -1;
  int            mon_cyc = 0;

  task automatic check_output(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [HW-1:0] mk_hdr(input int len, input int port, input int seq);
    return {16'(len), 16'(1000 + port), 16'(2000 + seq), 32'hC0A80100 + 32'(port), 32'h0A000000 + 32'(seq)};
  endfunction

  task automatic push_hdr(input int port, input logic [HW-1:0] h, input int hold_cycles);
    exp_t e;
    hdr_src[port].push_back(h);
    hold[port] = hold_cycles;
    e.is_hdr = 1'b1; e.port = port; e.hdr = h;
    e.data = '0; e.keep = '0; e.last = 1'b0; e.user = 1'b0;
    exp_q.push_back(e);
  endtask

  task automatic push_beat(input int port, input logic [DW-1:0] d, input logic [KW-1:0] k,
                           input bit l, input bit u, input bit expect_it);
    beat_t b;
    exp_t  e;
    b.data = d; b.keep = k; b.last = l; b.user = u;
    pld_src[port].push_back(b);
    if (expect_it) begin
      e.is_hdr = 1'b0; e.port = port; e.hdr = '0;
      e.data = d; e.keep = k; e.last = l; e.user = u;
      exp_q.push_back(e);
    end
  endtask

  // Generic packet: beats carry port/seq/index so any reordering or duplication shows up.
  task automatic apply_stimulus(input int port, input int len, input int nbeats, input int seq,
                                input int hold_cycles, input int exp_beats);
    push_hdr(port, mk_hdr(len, port, seq), hold_cycles);
    for (int b = 0; b < nbeats; b++)
      push_beat(port, {8'(8'hA0 + port), 8'(seq), 16'hBEEF, 24'h0, 8'(b)},
                (b == nbeats - 1) ? 8'h0F : 8'hFF, b == nbeats - 1,
                (b == nbeats - 1) && seq[0], b < exp_beats);
  endtask

  function automatic bit all_drained();
    bit d = (exp_q.size() == 0);
    for (int p = 0; p < NP; p++)
      if (hdr_src[p].size() != 0 || pld_src[p].size() != 0) d = 1'b0;
    return d;
  endfunction

  task automatic wait_done(input string name, input int max_cycles);
    bit ok = 1'b0;
    for (int i = 0; i < max_cycles && !ok; i++) begin
      @(posedge clk); #2;
      ok = all_drained();
    end
    if (!ok) begin
      nchk++;
      $display("[TB] FAIL %s: timeout with %0d expected beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
      for (int p = 0; p < NP; p++) begin hdr_src[p].delete(); pld_src[p].delete(); hold[p] = 0; end
    end
  endtask

  // Source driver: sample handshakes just before the edge, advance queues just after it.
  initial begin
    logic [NP-1:0] hf, pf;
    beat_t bt;
    s_hdr_data = '0; s_hdr_valid = '0;
    s_payload_axis_tdata = '0; s_payload_axis_tkeep = '0; s_payload_axis_tvalid = '0;
    s_payload_axis_tlast = '0; s_payload_axis_tuser = '0;
    m_hdr_ready = 1'b1; m_payload_axis_tready = 1'b1;
    for (int p = 0; p < NP; p++) hold[p] = 0;
    forever begin
      @(negedge clk); #4;
      hf = s_hdr_valid & s_hdr_ready;
      pf = s_payload_axis_tvalid & s_payload_axis_tready;
      @(posedge clk); #1;
      for (int p = 0; p < NP; p++) begin
        if (hf[p] && hdr_src[p].size() > 0) void'(hdr_src[p].pop_front());
        if (pf[p] && pld_src[p].size() > 0) void'(pld_src[p].pop_front());
        if (hold[p] > 0) hold[p]--;
        s_hdr_valid[p] = (hdr_src[p].size() > 0) && (hold[p] == 0);
        s_hdr_data[p*HW +: HW] = (hdr_src[p].size() > 0) ? hdr_src[p][0] : '0;
        if (pld_src[p].size() > 0) begin
          bt = pld_src[p][0];
          s_payload_axis_tvalid[p] = 1'b1;
          s_payload_axis_tdata[p*DW +: DW] = bt.data;
          s_payload_axis_tkeep[p*KW +: KW] = bt.keep;
          s_payload_axis_tlast[p] = bt.last;
          s_payload_axis_tuser[p] = bt.user;
        end else begin
          s_payload_axis_tvalid[p] = 1'b0;
          s_payload_axis_tdata[p*DW +: DW] = '0;
          s_payload_axis_tkeep[p*KW +: KW] = '0;
          s_payload_axis_tlast[p] = 1'b0;
          s_payload_axis_tuser[p] = 1'b0;
        end
      end
      m_hdr_ready = 1'b1;
      m_payload_axis_tready = bp_mode ? bp_pat[bp_i % 4] : 1'b1;
      if (bp_mode) bp_i++;
    end
  end

  // Monitor: tracks which requester should own the payload path and checks every handshake.
  initial begin
    exp_t          e;
    logic [NP-1:0] exp_rdy;
    logic [NP-1:0] onehot;
    forever begin
      @(negedge clk); #4;
      mon_cyc++;
      if (rst) begin mon_in_pld = 1'b0; mon_last_end = -1; end
      exp_rdy = '0;
      if (mon_in_pld && m_payload_axis_tready) exp_rdy[mon_cur] = 1'b1;
      check_output("pld_ready_vec", HW'(s_payload_axis_tready), HW'(exp_rdy));
      if (m_hdr_valid && m_hdr_ready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          $display("[TB] FAIL unexpected_hdr: got 0x%0h, expected no header", m_hdr_data);
        end else begin
          e = exp_q.pop_front();
          onehot = '0; onehot[e.port] = 1'b1;
          check_output("hdr_data", m_hdr_data, e.hdr);
          check_output("grant_idx", HW'(grant_idx), HW'(e.port));
          check_output("hdr_ready_vec", HW'(s_hdr_ready), HW'(onehot));
          if (check_gap && mon_last_end >= 0)
            check_output("inter_pkt_gap", HW'(mon_cyc - mon_last_end), HW'(2));
          mon_cur = e.port;
          if (e.hdr[HW-1 -: 16] <= 16'd8) begin mon_in_pld = 1'b0; mon_last_end = mon_cyc; end
          else mon_in_pld = 1'b1;
        end
      end
      if (m_payload_axis_tvalid && m_payload_axis_tready) begin
        if (exp_q.size() == 0) begin
          nchk++;
          $display("[TB] FAIL unexpected_beat: got 0x%0h, expected no beat", m_payload_axis_tdata);
        end else begin
          e = exp_q.pop_front();
          check_output("pld_data", HW'(m_payload_axis_tdata), HW'(e.data));
          check_output("pld_keep_last_user", HW'({m_payload_axis_tkeep, m_payload_axis_tlast, m_payload_axis_tuser}),
                       HW'({e.keep, e.last, e.user}));
          if (e.last) begin mon_in_pld = 1'b0; mon_last_end = mon_cyc; end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    #3;
    check_output("reset_hdr_valid", HW'(m_hdr_valid), HW'(0));
    check_output("reset_pld_valid", HW'(m_payload_axis_tvalid), HW'(0));
    check_output("reset_busy", HW'(busy), HW'(0));
    check_output("reset_pkt_count", HW'(pkt_count), HW'(0));
    check_output("reset_grant_idx", HW'(grant_idx), HW'(0));
    check_output("reset_hdr_ready", HW'(s_hdr_ready), HW'(0));
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    // Single requester with the fixed payload pattern; header appears one cycle after request.
    @(negedge clk);
    push_hdr(0, mk_hdr(24, 0, 0), 0);
    push_beat(0, 64'h0f0f0f0f0f0f0f0f, 8'hFF, 1'b0, 1'b0, 1'b1);
    push_beat(0, 64'h0101010101010101, 8'hFF, 1'b1, 1'b0, 1'b1);
    @(negedge clk); #4;
    check_output("hdr_valid_while_idle", HW'(m_hdr_valid), HW'(0));
    @(negedge clk); #4;
    check_output("hdr_valid_latency", HW'(m_hdr_valid), HW'(1));
    wait_done("single", 50);
    check_output("single_pkt_count", HW'(pkt_count), HW'(1));
    check_output("single_busy_after", HW'(busy), HW'(0));

    @(negedge clk) rst = 1'b1;
    #1 check_output("pulse_reset_pkt_count", HW'(pkt_count), HW'(0));
    @(negedge clk) rst = 1'b0;

    // Round robin over ports 0, 1, 3 from rr_ptr 0: order 0,1,3,0,1,3.
    @(negedge clk);
    check_gap = 1'b1;
    for (int s = 0; s < 2; s++) begin
      apply_stimulus(0, 16, 2, 10 + s, 0, 2);
      apply_stimulus(1, 16, 2, 20 + s, 0, 2);
      apply_stimulus(3, 16, 2, 30 + s, 0, 2);
    end
    wait_done("round_robin", 200);
    check_gap = 1'b0;
    check_output("rr_pkt_count", HW'(pkt_count), HW'(6));

    // Header-only datagram on port 2, then ports 0 and 3 together: rr_ptr=3 picks port 3 first.
    @(negedge clk);
    apply_stimulus(2, 8, 0, 40, 0, 0);
    wait_done("hdr_only", 50);
    check_output("hdr_only_pkt_count", HW'(pkt_count), HW'(7));
    @(negedge clk);
    apply_stimulus(3, 4, 0, 41, 0, 0);
    apply_stimulus(0, 8, 0, 42, 0, 0);
    wait_done("after_hdr_only", 50);
    check_output("after_hdr_only_pkt_count", HW'(pkt_count), HW'(9));

    // Payload backpressure 1,0,0,1 on a 4-beat packet.
    @(negedge clk);
    bp_mode = 1'b1; bp_i = 0;
    apply_stimulus(1, 32, 4, 50, 0, 4);
    wait_done("backpressure", 100);
    bp_mode = 1'b0;
    check_output("bp_pkt_count", HW'(pkt_count), HW'(10));

    // Early payload: port 1 payload is visible five cycles before its header.
    @(negedge clk);
    apply_stimulus(1, 16, 2, 61, 6, 2);
    repeat (3) @(negedge clk);
    #4;
    check_output("early_pld_valid", HW'(s_payload_axis_tvalid[1]), HW'(1));
    check_output("early_pld_stalled", HW'(s_payload_axis_tready[1]), HW'(0));
    wait_done("early_payload", 60);
    check_output("early_pkt_count", HW'(pkt_count), HW'(11));

    // Reset during the second payload beat of a port 2 packet.
    @(negedge clk);
    apply_stimulus(2, 24, 3, 70, 0, 1);
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(posedge clk); #2;
        seen = (exp_q.size() == 0);
      end
      check_output("first_beat_accepted", HW'(seen), HW'(1));
    end
    check_output("second_beat_presented", HW'(m_payload_axis_tvalid), HW'(1));
    rst = 1'b1;
    #1;
    check_output("midrst_pld_valid", HW'(m_payload_axis_tvalid), HW'(0));
    check_output("midrst_hdr_valid", HW'(m_hdr_valid), HW'(0));
    check_output("midrst_pld_ready", HW'(s_payload_axis_tready), HW'(0));
    check_output("midrst_busy", HW'(busy), HW'(0));
    check_output("midrst_pkt_count", HW'(pkt_count), HW'(0));
    exp_q.delete();
    for (int p = 0; p < NP; p++) begin hdr_src[p].delete(); pld_src[p].delete(); hold[p] = 0; end
    @(negedge clk);
    @(negedge clk) rst = 1'b0;

    // After reset, ports 1 and 3 together: arbitration restarts from port 0, so 1 wins first.
    @(negedge clk);
    apply_stimulus(1, 16, 2, 80, 0, 2);
    apply_stimulus(3, 16, 2, 81, 0, 2);
    wait_done("post_reset", 100);
    check_output("post_reset_pkt_count", HW'(pkt_count), HW'(2));

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
